// File: rtl/logo_pkg.sv
// Shared constants for the bouncing-logo system: sound codes, their priority,
// and default screen/logo dimensions used by the datapath and sound blocks.
package logo_pkg;

    typedef enum logic [1:0] {
        SND_STOP = 2'b00,
        SND_PONG = 2'b01,
        SND_PING = 2'b10,
        SND_GO   = 2'b11
    } sound_code_e;

    typedef enum logic {
        S_IDLE,
        S_PLAY
    } snd_state_e;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int LOGO_W   = 128;
    localparam int LOGO_H   = 64;

    // Priority rank, higher wins: go > pong > ping > stop.
    function automatic logic [1:0] snd_rank(input sound_code_e c);
        logic [1:0] r;
        case (c)
            SND_GO:   r = 2'd3;
            SND_PONG: r = 2'd2;
            SND_PING: r = 2'd1;
            default:  r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sound_arbiter.sv
// Prioritised sound FSM: turns bounce pulses into a timed code_sound/mute pair
// lasting SOUND_FRAMES frames; reset starts the go jingle.
module sound_arbiter
    import logo_pkg::*;
#(
    parameter int SOUND_FRAMES = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        frame_start,
    input  logic        bounce_x,
    input  logic        bounce_y,
    output sound_code_e code_sound,
    output logic        mute
);

    localparam int SCNT_W = (SOUND_FRAMES > 1) ? $clog2(SOUND_FRAMES) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SOUND_FRAMES - 1);

    snd_state_e        state_q, state_d;
    sound_code_e       code_q, code_d;
    logic              mute_q, mute_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;

    logic        ev;
    logic        last;
    logic        accept;
    sound_code_e ev_code;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        mute_d  = mute_q;
        scnt_d  = scnt_q;

        ev      = bounce_x | bounce_y;
        ev_code = bounce_x ? SND_PONG : SND_PING;
        last    = (state_q == S_PLAY) && frame_start && (scnt_q == SCNT_LAST);
        // A sound about to end accepts any event, so a coinciding hit is never lost.
        accept  = ev && ((state_q == S_IDLE) || last ||
                         (snd_rank(ev_code) >= snd_rank(code_q)));

        if (accept) begin
            state_d = S_PLAY;
            code_d  = ev_code;
            mute_d  = 1'b0;
            scnt_d  = '0;
        end else if ((state_q == S_PLAY) && frame_start) begin
            if (last) begin
                state_d = S_IDLE;
                code_d  = SND_STOP;
                mute_d  = 1'b1;
                scnt_d  = '0;
            end else begin
                scnt_d = scnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_PLAY;
            code_q  <= SND_GO;
            mute_q  <= 1'b0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            mute_q  <= mute_d;
            scnt_q  <= scnt_d;
        end
    end

    assign code_sound = code_q;
    assign mute       = mute_q;

endmodule

// File: rtl/logo_scheduler.sv
// Frame-synchronous scheduler: derives the position step enable from frame_start
// at a button-adjustable rate and hosts the sound arbiter.
module logo_scheduler
    import logo_pkg::*;
#(
    parameter int DIV_W         = 6,
    parameter int DIV_INIT      = 2,
    parameter int DIV_MIN       = 1,
    parameter int DIV_MAX       = 60,
    parameter int REPEAT_FRAMES = 30,
    parameter int SOUND_FRAMES  = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             frame_start,
    input  logic             inc_vel,
    input  logic             dec_vel,
    input  logic             pause,
    input  logic             bounce_x,
    input  logic             bounce_y,
    output logic             step,
    output logic [DIV_W-1:0] div_level,
    output logic [1:0]       code_sound,
    output logic             mute
);

    localparam int RCNT_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_FRAMES - 1);

    logic              step_q, step_d;
    logic [DIV_W-1:0]  fcnt_q, fcnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic [DIV_W-1:0]  div_m1;
    sound_code_e       snd_code;

    always_comb begin
        step_d = 1'b0;
        fcnt_d = fcnt_q;
        div_d  = div_q;
        rcnt_d = rcnt_q;
        div_m1 = div_q - 1'b1;

        if (frame_start) begin
            // >= so that lowering the divider below fcnt fires on the next frame.
            if (!pause) begin
                if (fcnt_q >= div_m1) begin
                    step_d = 1'b1;
                    fcnt_d = '0;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end

            if (inc_vel ^ dec_vel) begin
                if (rcnt_q == '0) begin
                    if (inc_vel && (div_q > DIV_W'(DIV_MIN)))
                        div_d = div_q - 1'b1;
                    else if (dec_vel && (div_q < DIV_W'(DIV_MAX)))
                        div_d = div_q + 1'b1;
                end
                rcnt_d = (rcnt_q == RCNT_LAST) ? '0 : rcnt_q + 1'b1;
            end else begin
                rcnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            step_q <= 1'b0;
            fcnt_q <= '0;
            div_q  <= DIV_W'(DIV_INIT);
            rcnt_q <= '0;
        end else begin
            step_q <= step_d;
            fcnt_q <= fcnt_d;
            div_q  <= div_d;
            rcnt_q <= rcnt_d;
        end
    end

    sound_arbiter #(
        .SOUND_FRAMES(SOUND_FRAMES)
    ) u_sound (
        .clk        (clk),
        .clr        (clr),
        .frame_start(frame_start),
        .bounce_x   (bounce_x),
        .bounce_y   (bounce_y),
        .code_sound (snd_code),
        .mute       (mute)
    );

    assign step       = step_q;
    assign div_level  = div_q;
    assign code_sound = snd_code;

endmodule

// File: tb/tb_logo_scheduler.sv
// Bench for logo_scheduler: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_logo_scheduler;
    import logo_pkg::*;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       frame_start = 1'b0;
    logic       inc_vel = 1'b0;
    logic       dec_vel = 1'b0;
    logic       pause = 1'b0;
    logic       bounce_x = 1'b0;
    logic       bounce_y = 1'b0;
    logic       step;
    logic [5:0] div_level;
    logic [1:0] code_sound;
    logic       mute;

    always #5 clk = ~clk;

    logo_scheduler dut (
        .clk        (clk),
        .clr        (clr),
        .frame_start(frame_start),
        .inc_vel    (inc_vel),
        .dec_vel    (dec_vel),
        .pause      (pause),
        .bounce_x   (bounce_x),
        .bounce_y   (bounce_y),
        .step       (step),
        .div_level  (div_level),
        .code_sound (code_sound),
        .mute       (mute)
    );

    int n_chk = 0;
    int n_fail = 0;
    int step_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: frames counted as plain integers.
    int         m_fcnt = 0;
    int         m_div = 2;
    int         m_hold = 0;
    int         m_scnt = 0;
    bit         m_step = 0;
    bit         m_play = 1;
    logic [1:0] m_code = SND_GO;
    bit         m_ev, m_last;
    logic [1:0] m_ec;

    function automatic int rank(input logic [1:0] c);
        case (c)
            SND_GO:   return 3;
            SND_PONG: return 2;
            SND_PING: return 1;
            default:  return 0;
        endcase
    endfunction

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_fcnt = 0; m_div = 2; m_hold = 0; m_step = 0;
            m_play = 1; m_code = SND_GO; m_scnt = 0;
        end else begin
            m_step = 0;
            if (frame_start && !pause) begin
                if (m_fcnt >= m_div - 1) begin
                    m_step = 1;
                    m_fcnt = 0;
                end else begin
                    m_fcnt++;
                end
            end
            if (frame_start) begin
                if (inc_vel != dec_vel) begin
                    if (m_hold % 30 == 0)
                        m_div = inc_vel ? ((m_div > 1) ? m_div - 1 : 1)
                                        : ((m_div < 60) ? m_div + 1 : 60);
                    m_hold++;
                end else begin
                    m_hold = 0;
                end
            end
            m_ev   = bounce_x || bounce_y;
            m_ec   = bounce_x ? SND_PONG : SND_PING;
            m_last = m_play && frame_start && (m_scnt == 7);
            if (m_ev && (!m_play || m_last || rank(m_ec) >= rank(m_code))) begin
                m_play = 1; m_code = m_ec; m_scnt = 0;
            end else if (m_play && frame_start) begin
                if (m_last) m_play = 0;
                else m_scnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (!clr) begin
            chk("step", {31'd0, step}, {31'd0, m_step});
            chk("div_level", {26'd0, div_level}, m_div);
            chk("code_sound", {30'd0, code_sound}, m_play ? {30'd0, m_code} : {30'd0, SND_STOP});
            chk("mute", {31'd0, mute}, {31'd0, !m_play});
            if (step) step_cnt++;
        end
    end

    task automatic frames(input int n);
        repeat (n) begin
            @(negedge clk); frame_start = 1'b1;
            @(negedge clk); frame_start = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic bounce(input bit bx, input bit by, input bit fs);
        @(negedge clk); bounce_x = bx; bounce_y = by; frame_start = fs;
        @(negedge clk); bounce_x = 1'b0; bounce_y = 1'b0; frame_start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        @(negedge clk);
    endtask

    int s0;

    initial begin
        repeat (3) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("reset step", {31'd0, step}, 0);
        chk("reset div", {26'd0, div_level}, 2);
        chk("reset code", {30'd0, code_sound}, SND_GO);
        chk("reset mute", {31'd0, mute}, 0);

        // Ten idle frames: go for eight, steps on every second frame.
        s0 = step_cnt;
        frames(7);
        chk("go frame7 mute", {31'd0, mute}, 0);
        chk("go frame7 code", {30'd0, code_sound}, SND_GO);
        frames(1);
        chk("go end mute", {31'd0, mute}, 1);
        chk("go end code", {30'd0, code_sound}, SND_STOP);
        frames(2);
        chk("steps in 10 frames", step_cnt - s0, 5);

        // Held inc saturates at 1.
        do_reset();
        inc_vel = 1'b1;
        s0 = step_cnt;
        frames(1);
        chk("inc frame1 div", {26'd0, div_level}, 1);
        frames(64);
        chk("inc sat div", {26'd0, div_level}, 1);
        chk("inc steps", step_cnt - s0, 64);
        inc_vel = 1'b0;

        // Held dec auto-repeats every 30 frames.
        do_reset();
        dec_vel = 1'b1;
        frames(30);
        chk("dec 30 div", {26'd0, div_level}, 3);
        frames(70);
        chk("dec 100 div", {26'd0, div_level}, 6);
        inc_vel = 1'b1;
        frames(10);
        chk("both held div", {26'd0, div_level}, 6);
        inc_vel = 1'b0; dec_vel = 1'b0;

        // Ping then pong preemption; later ping ignored.
        do_reset();
        frames(8);
        chk("idle mute", {31'd0, mute}, 1);
        bounce(1'b0, 1'b1, 1'b0);
        chk("ping code", {30'd0, code_sound}, SND_PING);
        chk("ping mute", {31'd0, mute}, 0);
        frames(2);
        bounce(1'b1, 1'b0, 1'b0);
        chk("pong code", {30'd0, code_sound}, SND_PONG);
        frames(3);
        bounce(1'b0, 1'b1, 1'b0);
        chk("ping dropped", {30'd0, code_sound}, SND_PONG);
        frames(4);
        chk("pong frame7 mute", {31'd0, mute}, 0);
        frames(1);
        chk("pong end mute", {31'd0, mute}, 1);

        // Simultaneous hits, then event on the terminating frame.
        bounce(1'b1, 1'b1, 1'b0);
        chk("both hits code", {30'd0, code_sound}, SND_PONG);
        frames(7);
        bounce(1'b0, 1'b1, 1'b1);
        chk("coincide code", {30'd0, code_sound}, SND_PING);
        chk("coincide mute", {31'd0, mute}, 0);
        frames(7);
        chk("restart frame7 mute", {31'd0, mute}, 0);
        frames(1);
        chk("restart end mute", {31'd0, mute}, 1);

        // Pause holds phase; clr mid-pause resets immediately.
        do_reset();
        frames(1);
        pause = 1'b1;
        s0 = step_cnt;
        frames(5);
        chk("paused steps", step_cnt - s0, 0);
        pause = 1'b0;
        frames(1);
        chk("resume step", step_cnt - s0, 1);
        dec_vel = 1'b1;
        frames(1);
        dec_vel = 1'b0;
        chk("pre-clr div", {26'd0, div_level}, 3);
        pause = 1'b1;
        frames(2);
        clr = 1'b1;
        #1;
        chk("clr div", {26'd0, div_level}, 2);
        chk("clr code", {30'd0, code_sound}, SND_GO);
        chk("clr mute", {31'd0, mute}, 0);
        chk("clr step", {31'd0, step}, 0);
        @(negedge clk); clr = 1'b0; pause = 1'b0;
        s0 = step_cnt;
        frames(1);
        chk("post-clr phase a", step_cnt - s0, 0);
        frames(1);
        chk("post-clr phase b", step_cnt - s0, 1);

        // Randomized traffic against the model.
        repeat (3000) begin
            @(negedge clk);
            frame_start = ($urandom_range(3) == 0);
            bounce_x    = ($urandom_range(15) == 0);
            bounce_y    = ($urandom_range(15) == 0);
            if ($urandom_range(40) == 0) inc_vel = 1'($urandom_range(1));
            if ($urandom_range(40) == 0) dec_vel = 1'($urandom_range(1));
            if ($urandom_range(60) == 0) pause = ~pause;
            clr = ($urandom_range(700) == 0);
        end
        @(negedge clk);
        clr = 1'b0; frame_start = 1'b0; bounce_x = 1'b0; bounce_y = 1'b0;
        inc_vel = 1'b0; dec_vel = 1'b0; pause = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
